uart_frame_tx: RTL and testbench



---
 rtl/uart_frame_tx.sv | 190 +++++++++++++++++++
 tb/tb_uart_frame_tx.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_tx.sv
// uart_frame_tx: sends HDR_BYTES fixed header bytes followed by PAY_BYTES
// latched payload bytes as back-to-back 8N1/8N2 characters on line_tx.
// Build option: define UART_FRAME_TX_PARITY_EN to add an even-parity bit
// after bit 7 of every character (8E1/8E2).
// Ports:
//   clk      system clock
//   rst      asynchronous, active-high reset
//   start    single-cycle frame request, sampled only while busy=0
//   payload  payload bytes, most-significant byte sent first
//   busy     frame in progress
//   done     one-cycle pulse when the last stop period completes
//   line_tx  serial output, idle high
module uart_frame_tx #(
  parameter int unsigned CLK_DIV   = 2500,
  parameter int unsigned HDR_BYTES = 4,
  parameter logic [63:0] HEADER    = 64'h0000_0000_AA07_0200,
  parameter int unsigned PAY_BYTES = 2,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [8*PAY_BYTES-1:0] payload,
  output logic                   busy,
  output logic                   done,
  output logic                   line_tx
);

  localparam int unsigned NB    = HDR_BYTES + PAY_BYTES;
  localparam int unsigned TMR_W = $clog2(CLK_DIV);
  localparam int unsigned IDX_W = $clog2(NB + 1);
  localparam int unsigned PAY_W = 8 * PAY_BYTES;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3
`ifdef UART_FRAME_TX_PARITY_EN
    , S_PAR = 3'd4
`endif
  } state_e;

  state_e             state_q, state_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [2:0]         bit_q, bit_d;
  logic               stop_q, stop_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [PAY_W-1:0]   pay_q, pay_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               line_q, line_d;

  logic [7:0]         byte_tbl [NB];
  logic [7:0]         cur_byte;
  logic               timer_wrap;
  logic [2:0]         bit_nxt;

  // Frame byte table: header constants first, then latched payload MSB-first.
  for (genvar gi = 0; gi < NB; gi++) begin : g_tbl
    if (gi < HDR_BYTES) begin : g_hdr
      assign byte_tbl[gi] = HEADER[8*(HDR_BYTES-gi)-1 -: 8];
    end else begin : g_pay
      assign byte_tbl[gi] = pay_q[8*(NB-gi)-1 -: 8];
    end
  end

  // Byte currently on the wire.
  always_comb begin
    cur_byte = 8'h00;
    for (int i = 0; i < NB; i++) begin
      if (idx_q == IDX_W'(i)) cur_byte = byte_tbl[i];
    end
  end

  assign timer_wrap = (timer_q == TMR_W'(CLK_DIV - 1));
  assign bit_nxt    = bit_q + 3'd1;

  // Next-state logic; line_d is the value the line takes next cycle, so the
  // registered output changes exactly on each state transition.
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    stop_d  = stop_q;
    idx_d   = idx_q;
    pay_d   = pay_q;
    busy_d  = busy_q;
    line_d  = line_q;
    done_d  = 1'b0;
    timer_d = (state_q == S_IDLE || timer_wrap) ? '0 : timer_q + TMR_W'(1);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_START;
          busy_d  = 1'b1;
          line_d  = 1'b0;
          idx_d   = '0;
          pay_d   = payload;
        end
      end
      S_START: begin
        if (timer_wrap) begin
          state_d = S_DATA;
          bit_d   = 3'd0;
          line_d  = cur_byte[0];
        end
      end
      S_DATA: begin
        if (timer_wrap) begin
          if (bit_q == 3'd7) begin
`ifdef UART_FRAME_TX_PARITY_EN
            state_d = S_PAR;
            line_d  = ^cur_byte;
`else
            state_d = S_STOP;
            stop_d  = 1'b0;
            line_d  = 1'b1;
`endif
          end else begin
            bit_d  = bit_nxt;
            line_d = cur_byte[bit_nxt];
          end
        end
      end
`ifdef UART_FRAME_TX_PARITY_EN
      S_PAR: begin
        if (timer_wrap) begin
          state_d = S_STOP;
          stop_d  = 1'b0;
          line_d  = 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (timer_wrap) begin
          if (stop_q == 1'(STOP_BITS - 1)) begin
            if (idx_q == IDX_W'(NB - 1)) begin
              state_d = S_IDLE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
              idx_d   = '0;
            end else begin
              state_d = S_START;
              idx_d   = idx_q + IDX_W'(1);
              line_d  = 1'b0;
            end
          end else begin
            stop_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        line_d  = 1'b1;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      idx_q   <= '0;
      pay_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      line_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      idx_q   <= idx_d;
      pay_q   <= pay_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      line_q  <= line_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign line_tx = line_q;

endmodule

// File: tb/tb_uart_frame_tx.sv
// tb_uart_frame_tx: directed checks of uart_frame_tx with CLK_DIV=4.
// u_dut0 uses the default header/payload layout; u_dut1 is header-less with
// three payload bytes and two stop bits.
module tb_uart_frame_tx;

  localparam int D = 4;
`ifdef UART_FRAME_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic        clk;
  logic        rst;
  logic        start0, start1;
  logic [15:0] payload0;
  logic [23:0] payload1;
  logic        busy0, done0, line0;
  logic        busy1, done1, line1;

  int vectors     = 0;
  int miscompares = 0;
  int done_cnt0   = 0;
  int done_cnt1   = 0;

  logic [7:0] exp_b [8];

  uart_frame_tx #(.CLK_DIV(D)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .payload(payload0),
    .busy(busy0), .done(done0), .line_tx(line0)
  );

  uart_frame_tx #(.CLK_DIV(D), .HDR_BYTES(0), .PAY_BYTES(3), .STOP_BITS(2)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .payload(payload1),
    .busy(busy1), .done(done1), .line_tx(line1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (done0) done_cnt0 <= done_cnt0 + 1;
    if (done1) done_cnt1 <= done_cnt1 + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic ln(input int sel);
    return (sel == 0) ? line0 : line1;
  endfunction

  function automatic logic bz(input int sel);
    return (sel == 0) ? busy0 : busy1;
  endfunction

  function automatic logic dn(input int sel);
    return (sel == 0) ? done0 : done1;
  endfunction

  // Deserialise one frame; called on the first start-bit cycle (k=0).
  // poke_k >= 0 re-pulses start0 with payload 16'hFFFF mid-frame.
  // chain raises start0 on the done cycle with chain_pay.
  task automatic rx_frame(input int sel, input int nb, input int stops,
                          input int poke_k, input bit chain, input logic [15:0] chain_pay);
    int cl;
    int total;
    logic [7:0] sh;
    cl    = 10 + stops - 1 + P;
    total = nb * cl * D;
    sh    = 8'h00;
    for (int k = 0; k <= total; k++) begin
      int c;
      int r;
      int b;
      if (k > 0) tick();
      if (poke_k >= 0 && k == poke_k) begin
        start0   = 1'b1;
        payload0 = 16'hFFFF;
      end
      if (poke_k >= 0 && k == poke_k + 1) start0 = 1'b0;
      if (k < total) begin
        c = k / (cl * D);
        r = k % (cl * D);
        b = r / D;
        if (r % D == D / 2) begin
          if (b == 0) begin
            chk("start_bit", 32'(ln(sel)), 32'd0);
            chk("busy_mid", 32'(bz(sel)), 32'd1);
          end else if (b <= 8) begin
            sh[3'(b - 1)] = ln(sel);
            if (b == 8) chk($sformatf("data_byte%0d", c), 32'(sh), 32'(exp_b[c]));
          end else if (b >= 9 + P) begin
            chk("stop_bit", 32'(ln(sel)), 32'd1);
          end
`ifdef UART_FRAME_TX_PARITY_EN
          else begin
            chk($sformatf("parity%0d", c), 32'(ln(sel)), 32'(^exp_b[c]));
          end
`endif
        end
        if (k == total - 1) chk("done_early", 32'(dn(sel)), 32'd0);
      end else begin
        chk("done_at_len", 32'(dn(sel)), 32'd1);
        chk("busy_at_done", 32'(bz(sel)), 32'd0);
        chk("line_at_done", 32'(ln(sel)), 32'd1);
        if (chain) begin
          start0   = 1'b1;
          payload0 = chain_pay;
        end
      end
    end
  endtask

  initial begin
    int low_seen;
    int cl0;
    rst      = 1'b1;
    start0   = 1'b0;
    start1   = 1'b0;
    payload0 = 16'h0000;
    payload1 = 24'h000000;
    cl0      = 10 + P;
    repeat (3) tick();
    chk("rst_line0", 32'(line0), 32'd1);
    chk("rst_busy0", 32'(busy0), 32'd0);
    chk("rst_done0", 32'(done0), 32'd0);
    chk("rst_line1", 32'(line1), 32'd1);
    rst = 1'b0;
    tick();

    // Default frame: AA 07 02 00 12 34, chained straight into a second frame.
    exp_b[0] = 8'hAA; exp_b[1] = 8'h07; exp_b[2] = 8'h02;
    exp_b[3] = 8'h00; exp_b[4] = 8'h12; exp_b[5] = 8'h34;
    payload0 = 16'h1234;
    start0   = 1'b1;
    tick();
    start0 = 1'b0;
    chk("latency_low", 32'(line0), 32'd0);
    chk("latency_busy", 32'(busy0), 32'd1);
    rx_frame(0, 6, 1, -1, 1'b1, 16'h1234);

    // Back-to-back: start on the done cycle gives a start bit next clock.
    tick();
    start0 = 1'b0;
    chk("b2b_low", 32'(line0), 32'd0);
    chk("b2b_busy", 32'(busy0), 32'd1);
    // Mid-frame start with new payload must be ignored.
    rx_frame(0, 6, 1, 100, 1'b0, 16'h0000);
    low_seen = 0;
    for (int i = 0; i < 2 * cl0 * D; i++) begin
      tick();
      if (line0 == 1'b0 || busy0 == 1'b1) low_seen++;
    end
    chk("no_second_frame", 32'(low_seen), 32'd0);
    chk("done_count_a", 32'(done_cnt0), 32'd2);

    // Abort with reset during byte 3, data bit 4.
    payload0 = 16'h0301;
    start0   = 1'b1;
    tick();
    start0 = 1'b0;
    for (int k = 1; k <= 3 * cl0 * D + 5 * D + 1; k++) tick();
    chk("busy_before_rst", 32'(busy0), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_line", 32'(line0), 32'd1);
    chk("abort_busy", 32'(busy0), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    tick();
    chk("abort_no_done", 32'(done_cnt0), 32'd2);

    // Fresh frame after abort: AA 07 02 00 03 01.
    exp_b[4] = 8'h03; exp_b[5] = 8'h01;
    payload0 = 16'h0301;
    start0   = 1'b1;
    tick();
    start0 = 1'b0;
    chk("fresh_low", 32'(line0), 32'd0);
    rx_frame(0, 6, 1, -1, 1'b0, 16'h0000);
    tick();
    chk("done_count_b", 32'(done_cnt0), 32'd3);

    // Header-less, three payload bytes, two stop bits.
    exp_b[0] = 8'hA5; exp_b[1] = 8'h01; exp_b[2] = 8'h80;
    payload1 = 24'hA5_01_80;
    start1   = 1'b1;
    tick();
    start1 = 1'b0;
    chk("nohdr_low", 32'(line1), 32'd0);
    rx_frame(1, 3, 2, -1, 1'b0, 16'h0000);
    tick();
    chk("done_count_1", 32'(done_cnt1), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
